math_adder_brent_kung_sum_pipe: RTL and testbench

MATH_ADDER_BRENT_KUNG_SUM_PIPE -- requirements
Module: math_adder_brent_kung_sum_pipe

---
 rtl/math_adder_brent_kung_sum_pipe_pkg.sv | 15 +
 rtl/math_adder_brent_kung_sum.sv | 20 ++
 rtl/math_adder_brent_kung_sum_pipe.sv | 111 +++++++++++
 tb/tb_math_adder_brent_kung_sum_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/math_adder_brent_kung_sum_pipe_pkg.sv
// Shared definitions for the Brent-Kung adder sum stage: skid-buffer state
// encoding and a small occupancy helper.
package math_adder_brent_kung_sum_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    function automatic logic holds_beat(input pipe_state_t s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/math_adder_brent_kung_sum.sv
// Final sum stage of a prefix adder: turns propagate and group-generate
// vectors into sum, carry out, signed overflow and zero flag.
module math_adder_brent_kung_sum #(
    parameter int N = 16
) (
    input  logic [N:0]   p,
    input  logic [N:0]   gg,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    // p[0] is the carry-in slot, so operand bit k pairs p[k+1] with gg[k].
    assign sum  = p[N:1] ^ gg[N-1:0];
    assign cout = gg[N];
    assign ovf  = gg[N] ^ gg[N-1];
    assign zero = ~|sum;

endmodule

// File: rtl/math_adder_brent_kung_sum_pipe.sv
// Registered sum stage with a main register and one skid register so that
// o_ready is a flop and never depends combinationally on i_ready.
module math_adder_brent_kung_sum_pipe
    import math_adder_brent_kung_sum_pipe_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N:0]   i_p,
    input  logic [N:0]   i_gg,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf,
    output logic         o_zero
);

    localparam int BW = N + 3;

    logic [N-1:0] sum_p0;
    logic         cout_p0;
    logic         ovf_p0;
    logic         zero_p0;
    logic [BW-1:0] beat_p0;

    math_adder_brent_kung_sum #(.N(N)) u_sum (
        .p    (i_p),
        .gg   (i_gg),
        .sum  (sum_p0),
        .cout (cout_p0),
        .ovf  (ovf_p0),
        .zero (zero_p0)
    );

    assign beat_p0 = {zero_p0, ovf_p0, cout_p0, sum_p0};

    pipe_state_t   state_q, state_d;
    logic          ready_q;
    logic [BW-1:0] main_p1;
    logic [BW-1:0] skid_p1;
    logic          accept;
    logic          deliver;
    logic          load_main_new;
    logic          load_main_skid;
    logic          load_skid;

    assign accept  = i_valid & ready_q;
    assign deliver = holds_beat(state_q) & i_ready;

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d       = ST_MAIN;
                    load_main_new = 1'b1;
                end
            end
            ST_MAIN: begin
                if (accept && deliver) begin
                    load_main_new = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d        = ST_MAIN;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // p0 -> p1: capture into main/skid registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            if (load_main_new) begin
                main_p1 <= beat_p0;
            end else if (load_main_skid) begin
                main_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= beat_p0;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = holds_beat(state_q);
    assign {o_zero, o_ovf, o_cout, o_sum} = main_p1;

endmodule

// File: tb/tb_math_adder_brent_kung_sum_pipe.sv
// Bench for the registered Brent-Kung sum stage: operands are turned into
// propagate/carry vectors and outputs are checked against plain a+b+cin.
module tb_math_adder_brent_kung_sum_pipe;

    localparam int N = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [N:0]    p_vec;
    logic [N:0]    gg_vec;
    logic          out_valid;
    logic          in_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;

    logic [N-1:0]  cur_a;
    logic [N-1:0]  cur_b;
    logic          cur_cin;

    int            n_checks;
    int            n_fail;
    logic          armed;
    logic [18:0]   exp_q[$];

    math_adder_brent_kung_sum_pipe #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_p     (p_vec),
        .i_gg    (gg_vec),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf),
        .o_zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {zero, ovf, cout, sum} from ordinary integer arithmetic.
    function automatic logic [18:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic cin);
        int unsigned u;
        int sa;
        int sb;
        int s;
        logic [N-1:0] r;
        u  = 32'(a) + 32'(b) + 32'(cin);
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb + int'(cin);
        r  = u[N-1:0];
        return {(r == '0), ((s > 32767) || (s < -32768)), u[16], r};
    endfunction

    // Golden ripple-prefix carries used only to build the DUT stimulus.
    task automatic set_beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        logic [N:0] c;
        c[0] = cin;
        for (int k = 0; k < N; k++) begin
            c[k+1] = (a[k] & b[k]) | ((a[k] ^ b[k]) & c[k]);
        end
        cur_a   = a;
        cur_b   = b;
        cur_cin = cin;
        p_vec   = {a ^ b, 1'b0};
        gg_vec  = c;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic v, input logic [N-1:0] s,
                                 input logic co, input logic o, input logic z);
        check({name, ".valid"}, 64'(out_valid), 64'(v));
        check({name, ".sum"},   64'(sum),       64'(s));
        check({name, ".cout"},  64'(cout),      64'(co));
        check({name, ".ovf"},   64'(ovf),       64'(o));
        check({name, ".zero"},  64'(zero),      64'(z));
    endtask

    // Scoreboard: outputs checked against the model queue before each edge,
    // then the queue is advanced by the handshakes that edge will perform.
    always @(negedge clk) begin
        if (armed) begin
            check("sb.valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("sb.ready", 64'(out_ready), 64'(exp_q.size() < 2));
            if (exp_q.size() > 0) begin
                check("sb.beat", 64'({zero, ovf, cout, sum}), 64'(exp_q[0]));
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (out_valid && in_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (in_valid && out_ready) begin
                exp_q.push_back(model(cur_a, cur_b, cur_cin));
            end
        end
    end

    initial begin
        int full_cycles;
        n_checks  = 0;
        n_fail    = 0;
        armed     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ready  = 1'b1;
        set_beat(16'h0000, 16'h0000, 1'b0);

        cyc();
        cyc();
        check_outputs("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("reset.ready", 64'(out_ready), 64'd1);

        // Model pinned against hand-computed values.
        check("model.wrap", 64'(model(16'hFFFF, 16'h0001, 1'b0)), 64'h50000);
        check("model.ovf",  64'(model(16'h7FFF, 16'h0001, 1'b0)), 64'h28000);

        rst_n = 1'b1;
        set_beat(16'hFFFF, 16'h0001, 1'b0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check_outputs("wrap", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc();

        set_beat(16'h7FFF, 16'h0001, 1'b0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check_outputs("ovf", 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        cyc();

        // Stall: two beats fill main and skid, extra beats must be ignored.
        in_ready = 1'b0;
        set_beat(16'h0001, 16'h0001, 1'b0);
        in_valid = 1'b1;
        cyc();
        check("stall1.sum", 64'(sum), 64'h0002);
        check("stall1.ready", 64'(out_ready), 64'd1);
        set_beat(16'h0002, 16'h0002, 1'b0);
        cyc();
        check("full.ready", 64'(out_ready), 64'd0);
        check("full.sum", 64'(sum), 64'h0002);
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0];
            set_beat(16'h5555 + 16'(i), 16'h1111, 1'b1);
            cyc();
            check("full.hold.sum", 64'(sum), 64'h0002);
            check("full.hold.ready", 64'(out_ready), 64'd0);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        cyc();
        check("drain1.sum", 64'(sum), 64'h0004);
        check("drain1.ready", 64'(out_ready), 64'd1);
        cyc();
        check("drain2.valid", 64'(out_valid), 64'd0);

        // Reset while full, then accept immediately after release.
        in_ready = 1'b0;
        in_valid = 1'b1;
        set_beat(16'h0010, 16'h0020, 1'b0);
        cyc();
        set_beat(16'h0030, 16'h0040, 1'b0);
        cyc();
        check("prerst.ready", 64'(out_ready), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        cyc();
        check_outputs("midrst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("midrst.ready", 64'(out_ready), 64'd1);
        rst_n    = 1'b1;
        in_ready = 1'b1;
        in_valid = 1'b1;
        set_beat(16'h1234, 16'h0001, 1'b0);
        cyc();
        in_valid = 1'b0;
        check_outputs("postrst", 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0);
        cyc();

        // Sustained valid/ready must give one beat per cycle.
        full_cycles = 0;
        in_valid = 1'b1;
        in_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            set_beat(16'($urandom), 16'($urandom), 1'($urandom));
            cyc();
            if (out_valid && out_ready) full_cycles++;
        end
        check("throughput", 64'(full_cycles), 64'd50);
        in_valid = 1'b0;
        cyc();
        cyc();

        for (int i = 0; i < 10000; i++) begin
            in_valid = (($urandom % 4) != 0);
            in_ready = (($urandom % 3) != 0);
            set_beat(16'($urandom), 16'($urandom), 1'($urandom));
            cyc();
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("final.empty", 64'(exp_q.size()), 64'd0);
        check("final.valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
